fetch_sequencer: RTL and testbench

Instruction-fetch and stage-sequencing unit for the multi-cycle Pillar core; it sits directly upstream of `decode`. It owns the program counter, fetches one 32-bit instruction at a time over a valid/ack memory port, holds it in the instruction register, and steps a global stage counter through FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK. `stage_o` and `ir_o` connect to `decode`'s `stage_i`/`ir_i`.

---
 rtl/pillar_pkg.sv | 30 +++
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pillar_pkg.sv
// -----------------------------------------------------------------------------
// pillar_pkg
// Shared definitions for the multi-cycle Pillar core.
//   stage_e       : global stage encoding, shared by fetch_sequencer and decode
//   NOP_INSN      : instruction register contents after reset
//   CAUSE_*       : fault cause codes reported on fault_cause_o
//   is_misaligned : true when a PC is not 4-byte aligned
// -----------------------------------------------------------------------------
package pillar_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd7
    } stage_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_FETCH_ERR  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the PC, fetches one 32-bit instruction over a valid/ack port into the
// instruction register, and steps the global stage counter
// FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK (TRAP on fault).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   imem_req_o/addr_o   : registered fetch request and its address (= pc_o)
//   imem_ack_i/rdata_i  : memory response and instruction word
//   imem_err_i          : bus error, qualified by imem_ack_i
//   stall_i             : hold DECODE..WRITEBACK
//   redirect_i/_pc_i    : taken branch target, sampled on WRITEBACK completion
//   stage_o, ir_o, pc_o : current stage, instruction register, PC
//   retire_o            : one-cycle pulse in the FETCH cycle after WRITEBACK
//   fault_o/cause_o     : sticky fault flag and cause
// -----------------------------------------------------------------------------
module fetch_sequencer
    import pillar_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [2:0]  stage_o,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        retire_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    stage_e      r_stage;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_req;
    logic        r_retire;
    logic        r_fault;
    logic [1:0]  r_cause;

    stage_e      w_stage_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_ir_next;
    logic        w_req_next;
    logic        w_retire_next;
    logic        w_fault_next;
    logic [1:0]  w_cause_next;

    logic [31:0] w_pc_seq;
    logic        w_redirect_bad;

    // Sequential PC wraps naturally at 32 bits.
    assign w_pc_seq       = r_pc + 32'd4;
    assign w_redirect_bad = redirect_i && is_misaligned(redirect_pc_i);

    // State register: stage FSM plus all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= NOP_INSN;
            r_req    <= 1'b0;
            r_retire <= 1'b0;
            r_fault  <= 1'b0;
            r_cause  <= CAUSE_NONE;
        end else begin
            r_stage  <= w_stage_next;
            r_pc     <= w_pc_next;
            r_ir     <= w_ir_next;
            r_req    <= w_req_next;
            r_retire <= w_retire_next;
            r_fault  <= w_fault_next;
            r_cause  <= w_cause_next;
        end
    end

    // Next-state logic: stage sequencing, fetch handshake, PC-next mux.
    always_comb begin
        w_stage_next  = r_stage;
        w_pc_next     = r_pc;
        w_ir_next     = r_ir;
        w_req_next    = r_req;
        w_retire_next = 1'b0;
        w_fault_next  = r_fault;
        w_cause_next  = r_cause;

        case (r_stage)
            ST_FETCH: begin
                // An ack is only meaningful while our request is outstanding.
                if (!r_req) begin
                    w_req_next = 1'b1;
                end else if (imem_ack_i) begin
                    w_req_next = 1'b0;
                    if (imem_err_i) begin
                        w_stage_next = ST_TRAP;
                        w_fault_next = 1'b1;
                        w_cause_next = CAUSE_FETCH_ERR;
                    end else begin
                        w_ir_next    = imem_rdata_i;
                        w_stage_next = ST_DECODE;
                    end
                end else begin
                    w_req_next = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!stall_i) begin
                    w_stage_next = ST_EXECUTE;
                end else begin
                    w_stage_next = ST_DECODE;
                end
            end
            ST_EXECUTE: begin
                if (!stall_i) begin
                    w_stage_next = ST_MEMORY;
                end else begin
                    w_stage_next = ST_EXECUTE;
                end
            end
            ST_MEMORY: begin
                if (!stall_i) begin
                    w_stage_next = ST_WRITEBACK;
                end else begin
                    w_stage_next = ST_MEMORY;
                end
            end
            ST_WRITEBACK: begin
                // Stall wins over redirect; redirect is resampled on completion.
                if (stall_i) begin
                    w_stage_next = ST_WRITEBACK;
                end else if (w_redirect_bad) begin
                    w_stage_next = ST_TRAP;
                    w_fault_next = 1'b1;
                    w_cause_next = CAUSE_MISALIGNED;
                end else begin
                    w_stage_next  = ST_FETCH;
                    w_retire_next = 1'b1;
                    w_pc_next     = redirect_i ? redirect_pc_i : w_pc_seq;
                end
            end
            ST_TRAP: begin
                w_req_next   = 1'b0;
                w_fault_next = 1'b1;
            end
            default: begin
                // Unused encodings are treated as a trap.
                w_stage_next = ST_TRAP;
                w_req_next   = 1'b0;
                w_fault_next = 1'b1;
            end
        endcase
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_pc;
    assign stage_o       = r_stage;
    assign ir_o          = r_ir;
    assign pc_o          = r_pc;
    assign retire_o      = r_retire;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_cause;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed stimulus for fetch_sequencer. Expected retirements and faults are
// queued as each instruction is driven; independent monitors pop and compare
// when the DUT pulses retire_o or raises fault_o.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import pillar_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_err_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [2:0]  stage_o;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        retire_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stage_o       (stage_o),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .retire_o      (retire_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ret_t;

    ret_t        ret_q[$];
    logic [1:0]  cause_q[$];
    logic        prev_fault = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] last_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Retirement monitor: each retire pulse must match the oldest queued entry.
    always @(negedge clk) begin : retire_monitor
        ret_t e;
        if (!reset && retire_o) begin
            if (ret_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL retire_unexpected actual=pulse required=none pc=%h", pc_o);
            end else begin
                e = ret_q.pop_front();
                chk("retire_next_pc", pc_o, e.pc);
                chk("retire_ir", ir_o, e.ir);
            end
        end
    end

    // Fault monitor: each rising fault_o must match the oldest queued cause.
    always @(negedge clk) begin : fault_monitor
        logic [1:0] c;
        if (reset) begin
            prev_fault <= 1'b0;
        end else begin
            if (fault_o && !prev_fault) begin
                if (cause_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fault_unexpected actual=cause%0d required=none", fault_cause_o);
                end else begin
                    c = cause_q.pop_front();
                    chk("fault_cause", {30'd0, fault_cause_o}, {30'd0, c});
                end
            end
            prev_fault <= fault_o;
        end
    end

    task automatic reset_dut();
        reset         = 1'b1;
        imem_ack_i    = 1'b0;
        imem_err_i    = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_pc  = 32'h0000_0000;
        last_ir = 32'h0000_0013;
        chk("rst_stage", {29'd0, stage_o}, 32'd0);
        chk("rst_pc", pc_o, 32'h0000_0000);
        chk("rst_ir", ir_o, 32'h0000_0013);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_retire", {31'd0, retire_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_cause", {30'd0, fault_cause_o}, 32'd0);
    endtask

    // Drive one instruction from its first FETCH cycle to retire or trap.
    // stall_stage: 0 none, 2 stall in EXECUTE, 4 stall in WRITEBACK.
    task automatic do_insn(input string tag, input logic [31:0] data, input int delay,
                           input bit err, input bit noise, input int stall_stage,
                           input int stall_n, input bit stall_redir,
                           input bit redir, input logic [31:0] rpc);
        int          t;
        int          lat;
        logic [31:0] nxt;
        bit          bad;
        t = 0;
        chk({tag, "_f0_stage"}, {29'd0, stage_o}, 32'd0);
        chk({tag, "_f0_req"}, {31'd0, imem_req_o}, 32'd0);
        if (noise) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
        end
        @(negedge clk); t++;
        imem_ack_i = 1'b0;
        chk({tag, "_req_up"}, {31'd0, imem_req_o}, 32'd1);
        chk({tag, "_addr"}, imem_addr_o, exp_pc);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); t++;
            chk({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd1);
            chk({tag, "_wait_addr"}, imem_addr_o, exp_pc);
            chk({tag, "_wait_stage"}, {29'd0, stage_o}, 32'd0);
        end
        imem_ack_i   = 1'b1;
        imem_rdata_i = data;
        imem_err_i   = err;
        if (err) cause_q.push_back(2'd1);
        @(negedge clk); t++;
        imem_ack_i   = 1'b0;
        imem_err_i   = 1'b0;
        imem_rdata_i = 32'h0;
        if (err) begin
            chk({tag, "_err_stage"}, {29'd0, stage_o}, 32'd7);
            chk({tag, "_err_ir"}, ir_o, last_ir);
            stall_i = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk({tag, "_err_req"}, {31'd0, imem_req_o}, 32'd0);
                chk({tag, "_err_hold"}, {29'd0, stage_o}, 32'd7);
                chk({tag, "_err_fault"}, {31'd0, fault_o}, 32'd1);
            end
            stall_i = 1'b0;
            return;
        end
        chk({tag, "_dec_stage"}, {29'd0, stage_o}, 32'd1);
        chk({tag, "_dec_ir"}, ir_o, data);
        chk({tag, "_dec_req"}, {31'd0, imem_req_o}, 32'd0);
        last_ir = data;
        if (noise) begin
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0300;
        end
        @(negedge clk); t++;
        redirect_i = 1'b0;
        chk({tag, "_ex_stage"}, {29'd0, stage_o}, 32'd2);
        if (stall_stage == 2) begin
            stall_i = 1'b1;
            for (int i = 0; i < stall_n; i++) begin
                @(negedge clk); t++;
                chk({tag, "_ex_hold"}, {29'd0, stage_o}, 32'd2);
            end
            stall_i = 1'b0;
        end
        @(negedge clk); t++;
        chk({tag, "_mem_stage"}, {29'd0, stage_o}, 32'd3);
        @(negedge clk); t++;
        chk({tag, "_wb_stage"}, {29'd0, stage_o}, 32'd4);
        if (stall_stage == 4) begin
            stall_i       = 1'b1;
            redirect_i    = stall_redir;
            redirect_pc_i = 32'h0000_0200;
            for (int i = 0; i < stall_n; i++) begin
                @(negedge clk); t++;
                chk({tag, "_wb_hold"}, {29'd0, stage_o}, 32'd4);
                chk({tag, "_wb_noretire"}, {31'd0, retire_o}, 32'd0);
            end
            stall_i = 1'b0;
        end
        redirect_i    = redir;
        redirect_pc_i = rpc;
        bad = redir && (rpc[1:0] != 2'b00);
        nxt = redir ? rpc : exp_pc + 32'd4;
        if (bad) cause_q.push_back(2'd2);
        else ret_q.push_back('{pc: nxt, ir: data});
        @(negedge clk); t++;
        redirect_i = 1'b0;
        if (bad) begin
            chk({tag, "_trap_stage"}, {29'd0, stage_o}, 32'd7);
            chk({tag, "_trap_pc"}, pc_o, exp_pc);
            repeat (3) begin
                chk({tag, "_trap_retire"}, {31'd0, retire_o}, 32'd0);
                @(negedge clk);
                chk({tag, "_trap_req"}, {31'd0, imem_req_o}, 32'd0);
                chk({tag, "_trap_hold"}, {29'd0, stage_o}, 32'd7);
            end
        end else begin
            lat = 6 + delay + ((stall_stage != 0) ? stall_n : 0);
            chk({tag, "_ret_stage"}, {29'd0, stage_o}, 32'd0);
            chk({tag, "_ret_pulse"}, {31'd0, retire_o}, 32'd1);
            chk({tag, "_latency"}, t, lat);
            exp_pc = nxt;
        end
    endtask

    initial begin
        exp_pc  = 32'h0;
        last_ir = 32'h0000_0013;
        reset_dut();
        // zero-wait, plus an ack while req=0 and a redirect outside WRITEBACK
        do_insn("a", 32'h0010_0093, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 32'h0);
        do_insn("b", 32'h0020_8113, 3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
        do_insn("c", 32'h0031_0193, 0, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0, 32'h0);
        do_insn("d", 32'h0000_006F, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0000_0100);
        do_insn("e", 32'h0000_0067, 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        do_insn("wrap", 32'h0041_8213, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", exp_pc, 32'h0000_0000);
        do_insn("misal", 32'h0000_00EF, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0000_0102);
        chk("misal_cause_out", {30'd0, fault_cause_o}, 32'd2);
        reset_dut();
        // stall and redirect together in WRITEBACK: stall wins, redirect resampled
        do_insn("wbstall", 32'h0052_0293, 0, 1'b0, 1'b0, 4, 2, 1'b1, 1'b0, 32'h0);
        chk("wbstall_pc", pc_o, 32'h0000_0004);
        do_insn("buserr", 32'h1234_5678, 2, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
        chk("buserr_cause_out", {30'd0, fault_cause_o}, 32'd1);
        reset_dut();
        // reset and ack in the same cycle, ack lingering into first post-reset cycle
        @(negedge clk);
        chk("rw_req", {31'd0, imem_req_o}, 32'd1);
        reset        = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_ir", ir_o, 32'h0000_0013);
        chk("rw_req_drop", {31'd0, imem_req_o}, 32'd0);
        chk("rw_stage", {29'd0, stage_o}, 32'd0);
        @(negedge clk);
        imem_ack_i = 1'b0;
        chk("rw_post_ir", ir_o, 32'h0000_0013);
        chk("rw_post_stage", {29'd0, stage_o}, 32'd0);
        chk("rw_post_req", {31'd0, imem_req_o}, 32'd1);
        chk("rw_post_addr", imem_addr_o, 32'h0000_0000);
        repeat (2) @(negedge clk);
        chk("retire_q_empty", ret_q.size(), 32'd0);
        chk("fault_q_empty", cause_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
